mac_pipe: RTL and testbench
===========================

# mac_pipe

Pipelined, parametrised signed multiply-accumulate for the LNS MAC datapath, successor to the single-lane MAC. Each accepted input beat carries LANES pairs of signed operands. Their products are summed and accumulated over DOT_LEN beats, or fewer when data_in_last is asserted. The saturated dot product is then emitted through a held output register. Valid/enable handshakes on both sides give full throughput with backpressure, and the block sits between the operand streamer and the result collector.

## Interface
- IN_BITS, 14, operand MSB index; each operand is IN_BITS+1 bits, two's complement
- LANES, 4, operand pairs per beat (≥1)
- ACC_BITS, 31, result MSB index; the result is ACC_BITS+1 bits (≥ 2*IN_BITS+1)
- DOT_LEN, 16, beats per result when data_in_last is not asserted (≥1)
- clk  in  1  clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- clr  in  1  qualified by an accepted beat; discard the running sum and beat count before adding this beat
- data_in_valid  in  1  input beat present
- data_in_last  in  1  qualified by an accepted beat; this beat ends the current result
- data_in_x  in  LANES*(IN_BITS+1)  packed signed operands, lane 0 in the LSBs
- data_in_y  in  LANES*(IN_BITS+1)  packed signed operands, lane 0 in the LSBs
- data_in_enable  out  1  block accepts a beat this cycle
- data_out_enable  in  1  consumer accepts the result this cycle
- data_out_valid  out  1  r_accum and data_out_ovf hold an unconsumed result
- r_accum  out  ACC_BITS+1  saturated signed dot product
- data_out_ovf  out  1  saturation occurred at least once during this result

## Operation
- A beat is accepted on a rising edge where data_in_valid && data_in_enable.
- Stage 1 (lane sum):
  - sum of LANES signed products, computed at full precision (2*(IN_BITS+1)+clog2(LANES) bits);
  - registered into s1_sum, together with s1_valid, s1_clr and s1_last.
- Stage 2 (accumulate):
  - base = s1_clr ? 0 : acc;
  - t = base + sign-extended s1_sum, evaluated one bit wider than the result;
  - t saturates to [-2^ACC_BITS, 2^ACC_BITS-1].
- Overflow tracking:
  - ovf_sticky is set whenever saturation occurs;
  - s1_clr resets ovf_sticky before the OR.
- Beat counter cnt runs 0..DOT_LEN-1.
  - A beat is the final beat when s1_last is set or cnt==DOT_LEN-1.
  - s1_clr restarts counting, so the clr beat is beat 0.
- Non-final beat: acc ← saturated t; cnt ← cnt+1.
- Final beat:
  - r_accum ← saturated t; data_out_ovf ← combined sticky; data_out_valid ← 1;
  - acc ← 0, cnt ← 0, ovf_sticky ← 0, so the next result starts clean.
- Output register holds its value until data_out_valid && data_out_enable. If that handshake occurs and no new final beat completes, data_out_valid ← 0.
- Stage 2 can advance (s2_go) when:
  - there is no stage-1 beat; or
  - the stage-1 beat is not final; or
  - the output register is free: !data_out_valid || data_out_enable.
- data_in_enable = !s1_valid || s2_go. Stage 1 holds its contents while stalled.
- Reset (rstn low, asynchronous):
  - s1_valid, acc, cnt and ovf_sticky clear to 0;
  - outputs: data_out_valid=0, r_accum=0, data_out_ovf=0, data_in_enable=1 (combinational from s1_valid=0).
- Reset mid-result discards any partial sum without emitting it.

## Timing
- Latency: a final beat accepted at edge N produces data_out_valid=1 and r_accum valid after edge N+1.
- Throughput: one beat per cycle when the consumer holds data_out_enable=1.
- Back-to-back final beats (DOT_LEN=1 or data_in_last every beat) produce one result per cycle.
- The same-cycle case where the output is consumed and a new final beat completes loads the new result; data_out_valid stays 1.
- Output full and stage 1 holding a final beat: data_in_enable=0 in that cycle, and no beat is lost.
- data_out_enable when data_out_valid=0 has no effect.
- clr and data_in_last together: a single-beat result equal to this beat's products.

## Structure
- Package mac_pkg holds:
  - width constants/functions: operand width, lane-sum width, accumulator width;
  - the saturate function (wide signed to ACC_BITS+1 bits, returning value and ovf).
- Sub-module mac_lane_sum holds the LANES multipliers, the adder tree and the stage-1 register with its valid/stall handling.
- mac_pipe holds stage 2, the counter, the output register and the handshake logic.

## Test plan
- Reset check: LANES=4, DOT_LEN=4. After reset, all outputs are 0 and data_in_enable=1.
- Four beats, x=y={1,2,3,4}, consumer ready: one result r_accum=120, data_out_ovf=0, valid exactly once, two cycles after the first beat is accepted plus three beats.
- Backpressure: hold data_out_enable=0 through two complete results.
  - The first result stays stable; data_in_enable drops when the second final beat reaches stage 1.
  - On release, 120 is emitted, then the second result; no beat is lost or duplicated.
- Overflow: IN_BITS=14, ACC_BITS=31, all operands -16384 (-2^14), DOT_LEN=16 → 16×4×2^28 = 2^34 is clamped to r_accum=2^31-1 with data_out_ovf=1. The next result is 120 with data_out_ovf=0.
- Early termination and clear:
  - data_in_last on beat 2 of 4 → result is the 2-beat sum, and the counter restarts.
  - clr on the middle of three beats → result is the sum of the last two beats only.
- Reset mid-result: assert rstn low after 2 of 4 beats, then send 4 fresh beats → one result equal to the fresh-beat sum only.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and the saturation helper for the pipelined signed MAC.
package mac_pkg;

   // Working width for the stage-2 sum before it is clamped to the result width.
   localparam int unsigned SAT_W = 64;

   // Clamped value (low ACC_BITS+1 bits meaningful) plus a flag that clamping happened.
   typedef struct packed {
      logic [SAT_W-1:0] val;
      logic             ovf;
   } sat_t;

   // Width of one two's-complement operand.
   function automatic int unsigned op_w(input int unsigned in_bits);
      return in_bits + 1;
   endfunction

   // Full-precision width of the sum of all lane products.
   function automatic int unsigned sum_w(input int unsigned in_bits, input int unsigned lanes);
      return 2 * (in_bits + 1) + $clog2(lanes);
   endfunction

   // Width of the accumulator and result.
   function automatic int unsigned acc_w(input int unsigned acc_bits);
      return acc_bits + 1;
   endfunction

   // Width of the beat counter (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned dot_len);
      return (dot_len > 1) ? $clog2(dot_len) : 1;
   endfunction

   // Clamp a wide signed value to [-2^acc_bits, 2^acc_bits-1].
   function automatic sat_t saturate(input logic signed [SAT_W-1:0] v,
                                     input int unsigned            acc_bits);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_t                    r;
      hi    = (64'sd1 <<< acc_bits) - 64'sd1;
      lo    = -(64'sd1 <<< acc_bits);
      r.ovf = 1'b1;
      if (v > hi) begin
         r.val = hi;
      end else if (v < lo) begin
         r.val = lo;
      end else begin
         r.val = v;
         r.ovf = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_pipe_lane_sum.sv
// Stage 1: LANES signed multipliers, adder tree and the stage-1 register.
module mac_lane_sum
   import mac_pkg::*;
#(
   parameter int unsigned IN_BITS = 14,
   parameter int unsigned LANES   = 4
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    in_valid,
   input  logic                                    in_clr,
   input  logic                                    in_last,
   input  logic [LANES*(IN_BITS+1)-1:0]            in_x,
   input  logic [LANES*(IN_BITS+1)-1:0]            in_y,
   input  logic                                    s2_go,
   output logic                                    in_enable,
   output logic                                    s1_valid,
   output logic                                    s1_clr,
   output logic                                    s1_last,
   output logic signed [sum_w(IN_BITS,LANES)-1:0] s1_sum
);

   localparam int unsigned OP_W  = op_w(IN_BITS);
   localparam int unsigned SUM_W = sum_w(IN_BITS, LANES);

   logic signed [OP_W-1:0]  lane_x;
   logic signed [OP_W-1:0]  lane_y;
   logic signed [SUM_W-1:0] lane_sum;

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_clr_q,   s1_clr_d;
   logic                    s1_last_q,  s1_last_d;
   logic signed [SUM_W-1:0] s1_sum_q,   s1_sum_d;

   // Stage 1 takes a new beat whenever it is empty or stage 2 drains it.
   assign in_enable = !s1_valid_q || s2_go;

   // Sum of lane products at full precision.
   always_comb begin
      lane_x   = '0;
      lane_y   = '0;
      lane_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_x   = in_x[i*OP_W +: OP_W];
         lane_y   = in_y[i*OP_W +: OP_W];
         lane_sum = lane_sum + SUM_W'(lane_x) * SUM_W'(lane_y);
      end
   end

   // Load the stage-1 register when enabled, otherwise hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_clr_d   = s1_clr_q;
      s1_last_d  = s1_last_q;
      s1_sum_d   = s1_sum_q;
      if (in_enable) begin
         s1_valid_d = in_valid;
         s1_clr_d   = in_clr;
         s1_last_d  = in_last;
         s1_sum_d   = lane_sum;
      end
   end

   // Stage-1 register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_clr_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sum_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_clr_q   <= s1_clr_d;
         s1_last_q  <= s1_last_d;
         s1_sum_q   <= s1_sum_d;
      end
   end

   assign s1_valid = s1_valid_q;
   assign s1_clr   = s1_clr_q;
   assign s1_last  = s1_last_q;
   assign s1_sum   = s1_sum_q;

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed dot-product MAC: stage-2 accumulate, beat counter and held output register.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int unsigned IN_BITS  = 14,
   parameter int unsigned LANES    = 4,
   parameter int unsigned ACC_BITS = 31,
   parameter int unsigned DOT_LEN  = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clr,
   input  logic                          data_in_valid,
   input  logic                          data_in_last,
   input  logic [LANES*(IN_BITS+1)-1:0]  data_in_x,
   input  logic [LANES*(IN_BITS+1)-1:0]  data_in_y,
   output logic                          data_in_enable,
   input  logic                          data_out_enable,
   output logic                          data_out_valid,
   output logic signed [ACC_BITS:0]      r_accum,
   output logic                          data_out_ovf
);

   localparam int unsigned SUM_W = sum_w(IN_BITS, LANES);
   localparam int unsigned ACC_W = acc_w(ACC_BITS);
   localparam int unsigned CNT_W = cnt_w(DOT_LEN);

   logic                    s1_valid;
   logic                    s1_clr;
   logic                    s1_last;
   logic signed [SUM_W-1:0] s1_sum;
   logic                    s2_go;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sticky_q, sticky_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] r_q, r_d;
   logic                    ovf_q, ovf_d;

   logic [CNT_W-1:0]        cnt_eff;
   logic                    final_beat;
   logic                    sticky_now;
   logic signed [SAT_W-1:0] base_w;
   logic signed [SAT_W-1:0] sum_wide;
   logic signed [SAT_W-1:0] t_wide;
   sat_t                    sat_res;
   logic                    sat_hi_unused;

   mac_lane_sum #(
      .IN_BITS (IN_BITS),
      .LANES   (LANES)
   ) u_lane_sum (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (data_in_valid),
      .in_clr    (clr),
      .in_last   (data_in_last),
      .in_x      (data_in_x),
      .in_y      (data_in_y),
      .s2_go     (s2_go),
      .in_enable (data_in_enable),
      .s1_valid  (s1_valid),
      .s1_clr    (s1_clr),
      .s1_last   (s1_last),
      .s1_sum    (s1_sum)
   );

   // Saturation leaves the upper bits as pure sign copies.
   assign sat_hi_unused = ^sat_res.val[SAT_W-1:ACC_W];

   // Stage-2 datapath: clear-aware base, wide add, clamp, final-beat and advance decisions.
   always_comb begin
      cnt_eff    = s1_clr ? '0 : cnt_q;
      final_beat = s1_last || (cnt_eff == CNT_W'(DOT_LEN - 1));
      if (s1_clr) begin
         base_w = '0;
      end else begin
         base_w = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
      end
      sum_wide   = {{(SAT_W-SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
      t_wide     = base_w + sum_wide;
      sat_res    = saturate(t_wide, ACC_BITS);
      sticky_now = (s1_clr ? 1'b0 : sticky_q) | sat_res.ovf;
      s2_go      = !s1_valid || !final_beat || !out_valid_q || data_out_enable;
   end

   // Next state for accumulator, counter, sticky flag and the held output register.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sticky_d    = sticky_q;
      r_d         = r_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q && !data_out_enable;
      if (s1_valid && s2_go) begin
         if (final_beat) begin
            r_d         = sat_res.val[ACC_W-1:0];
            ovf_d       = sticky_now;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
         end else begin
            acc_d    = sat_res.val[ACC_W-1:0];
            cnt_d    = cnt_eff + CNT_W'(1);
            sticky_d = sticky_now;
         end
      end
   end

   // Stage-2 and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         r_q         <= '0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         r_q         <= r_d;
         ovf_q       <= ovf_d;
      end
   end

   assign data_out_valid = out_valid_q;
   assign r_accum        = r_q;
   assign data_out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: a driver feeds beats and a reference model queues
// expected results; a negedge monitor pops and compares on every output handshake.
module tb_mac_pipe;

   localparam int unsigned IN_BITS  = 14;
   localparam int unsigned LANES    = 4;
   localparam int unsigned ACC_BITS = 31;
   localparam int unsigned DOT_LEN  = 4;
   localparam int unsigned OPW      = IN_BITS + 1;
   localparam int unsigned PW       = LANES * OPW;
   localparam longint      SMAX     = (longint'(1) <<< ACC_BITS) - 1;
   localparam longint      SMIN     = -(longint'(1) <<< ACC_BITS);

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   clr;
   logic                   data_in_valid;
   logic                   data_in_last;
   logic [PW-1:0]          data_in_x;
   logic [PW-1:0]          data_in_y;
   logic                   data_in_enable;
   logic                   data_out_enable;
   logic                   data_out_valid;
   logic signed [ACC_BITS:0] r_accum;
   logic                   data_out_ovf;

   typedef struct {
      longint val;
      bit     ovf;
   } exp_t;

   exp_t   exp_q[$];
   int     n_vec  = 0;
   int     n_fail = 0;
   bit     rand_ready = 1'b0;

   // Reference model state: running sum, beats in current result, saturation seen.
   longint m_acc = 0;
   int     m_cnt = 0;
   bit     m_ovf = 1'b0;

   always #5 clk = ~clk;

   mac_pipe #(
      .IN_BITS  (IN_BITS),
      .LANES    (LANES),
      .ACC_BITS (ACC_BITS),
      .DOT_LEN  (DOT_LEN)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .clr             (clr),
      .data_in_valid   (data_in_valid),
      .data_in_last    (data_in_last),
      .data_in_x       (data_in_x),
      .data_in_y       (data_in_y),
      .data_in_enable  (data_in_enable),
      .data_out_enable (data_out_enable),
      .data_out_valid  (data_out_valid),
      .r_accum         (r_accum),
      .data_out_ovf    (data_out_ovf)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [PW-1:0] p;
      p = '0;
      p[0*OPW +: OPW] = OPW'(a0);
      p[1*OPW +: OPW] = OPW'(a1);
      p[2*OPW +: OPW] = OPW'(a2);
      p[3*OPW +: OPW] = OPW'(a3);
      return p;
   endfunction

   task automatic model_reset();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endtask

   // Dot product of the beat, clamp after each addition, emit on last beat or DOT_LEN beats.
   task automatic model_accept(input logic [PW-1:0] x, input logic [PW-1:0] y,
                               input bit c, input bit l);
      longint s;
      longint t;
      logic signed [OPW-1:0] a;
      logic signed [OPW-1:0] b;
      exp_t e;
      s = 0;
      for (int i = 0; i < int'(LANES); i++) begin
         a = x[i*OPW +: OPW];
         b = y[i*OPW +: OPW];
         s += longint'(a) * longint'(b);
      end
      if (c) model_reset();
      t = m_acc + s;
      if (t > SMAX) begin
         t = SMAX;
         m_ovf = 1'b1;
      end else if (t < SMIN) begin
         t = SMIN;
         m_ovf = 1'b1;
      end
      if (l || m_cnt == int'(DOT_LEN) - 1) begin
         e.val = t;
         e.ovf = m_ovf;
         exp_q.push_back(e);
         model_reset();
      end else begin
         m_acc = t;
         m_cnt++;
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
      if (rand_ready) data_out_enable = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      data_in_valid = 1'b0;
      clr           = 1'b0;
      data_in_last  = 1'b0;
      repeat (n) after_edge();
   endtask

   // Present one beat and hold it until the DUT accepts it (bounded wait).
   task automatic send_beat(input logic [PW-1:0] x, input logic [PW-1:0] y,
                            input bit c, input bit l);
      int waited;
      waited        = 0;
      data_in_x     = x;
      data_in_y     = y;
      clr           = c;
      data_in_last  = l;
      data_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (data_in_enable) break;
         waited++;
         if (waited > 200) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: data_in_enable stayed 0 for %0d cycles, required 1", waited);
            data_in_valid = 1'b0;
            return;
         end
         after_edge();
      end
      @(posedge clk);
      model_accept(x, y, c, l);
      #1;
      data_in_valid = 1'b0;
      clr           = 1'b0;
      data_in_last  = 1'b0;
      if (rand_ready) data_out_enable = 1'($urandom_range(0, 1));
   endtask

   // Monitor: every output handshake must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rstn && data_out_valid && data_out_enable) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_result: got r_accum=%0d, expected no result", r_accum);
         end else begin
            e = exp_q.pop_front();
            chk("result_val", longint'(r_accum), e.val);
            chk("result_ovf", longint'(data_out_ovf), longint'(e.ovf));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] v1234;
      logic [PW-1:0] vneg;
      logic [PW-1:0] rx;
      logic [PW-1:0] ry;
      logic [63:0]   rr;
      int            waited;

      v1234           = pack4(1, 2, 3, 4);
      vneg            = pack4(-16384, -16384, -16384, -16384);
      rstn            = 1'b0;
      clr             = 1'b0;
      data_in_valid   = 1'b0;
      data_in_last    = 1'b0;
      data_in_x       = '0;
      data_in_y       = '0;
      data_out_enable = 1'b1;

      // Reset state
      #3;
      chk("rst_valid",  longint'(data_out_valid), 0);
      chk("rst_accum",  longint'(r_accum), 0);
      chk("rst_ovf",    longint'(data_out_ovf), 0);
      chk("rst_in_en",  longint'(data_in_enable), 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      after_edge();

      // Four beats of {1,2,3,4}.{1,2,3,4}: 30 per beat, 120 total, one cycle after last accept
      for (int i = 0; i < 4; i++) send_beat(v1234, v1234, 1'b0, 1'b0);
      chk("lat_not_yet", longint'(data_out_valid), 0);
      after_edge();
      chk("lat_valid", longint'(data_out_valid), 1);
      chk("t1_accum",  longint'(r_accum), 120);
      chk("t1_ovf",    longint'(data_out_ovf), 0);
      after_edge();
      chk("t1_once",   longint'(data_out_valid), 0);

      // Backpressure through two complete results (second result 4 x 8 = 32)
      data_out_enable = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(v1234, v1234, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 1'b0);
      chk("bp_in_en_low", longint'(data_in_enable), 0);
      for (int i = 0; i < 3; i++) begin
         after_edge();
         chk("bp_hold_valid", longint'(data_out_valid), 1);
         chk("bp_hold_accum", longint'(r_accum), 120);
         chk("bp_in_en_held", longint'(data_in_enable), 0);
      end
      data_out_enable = 1'b1;
      idle(3);
      chk("bp_drained", longint'(exp_q.size()), 0);

      // Overflow: 4 x 4 x 2^28 = 2^32 clamps to 2^31-1, then a clean 120
      for (int i = 0; i < 4; i++) send_beat(vneg, vneg, 1'b0, 1'b0);
      after_edge();
      chk("ovf_accum", longint'(r_accum), SMAX);
      chk("ovf_flag",  longint'(data_out_ovf), 1);
      for (int i = 0; i < 4; i++) send_beat(v1234, v1234, 1'b0, 1'b0);
      after_edge();
      chk("post_ovf_accum", longint'(r_accum), 120);
      chk("post_ovf_flag",  longint'(data_out_ovf), 0);

      // Early last on beat 2 (60), then four fresh beats of 4 each (16)
      send_beat(v1234, v1234, 1'b0, 1'b0);
      send_beat(v1234, v1234, 1'b0, 1'b1);
      after_edge();
      chk("last_valid", longint'(data_out_valid), 1);
      chk("last_accum", longint'(r_accum), 60);
      for (int i = 0; i < 4; i++) send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 1'b0);
      after_edge();
      chk("restart_accum", longint'(r_accum), 16);

      // clr on the middle of three beats: 20 discarded, 30 + 30 kept
      send_beat(pack4(5, 5, 5, 5), pack4(1, 1, 1, 1), 1'b0, 1'b0);
      send_beat(v1234, v1234, 1'b1, 1'b0);
      send_beat(v1234, v1234, 1'b0, 1'b1);
      after_edge();
      chk("clr_accum", longint'(r_accum), 60);

      // clr and last together: single-beat result
      send_beat(pack4(-3, 7, 0, 2), pack4(4, -1, 9, 5), 1'b1, 1'b1);
      after_edge();
      chk("clr_last_accum", longint'(r_accum), -9);
      idle(2);

      // Reset after two of four beats; only the fresh 4 x 24 = 96 appears
      send_beat(v1234, v1234, 1'b0, 1'b0);
      send_beat(v1234, v1234, 1'b0, 1'b0);
      rstn = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_valid", longint'(data_out_valid), 0);
      chk("mid_rst_accum", longint'(r_accum), 0);
      chk("mid_rst_in_en", longint'(data_in_enable), 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 1'b0, 1'b0);
      after_edge();
      chk("mid_rst_fresh", longint'(r_accum), 96);
      idle(2);

      // Randomized operands, clr/last and consumer readiness
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rr = {$urandom(), $urandom()};
         rx = rr[PW-1:0];
         rr = {$urandom(), $urandom()};
         ry = rr[PW-1:0];
         send_beat(rx, ry, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      rand_ready      = 1'b0;
      data_out_enable = 1'b1;
      data_in_valid   = 1'b0;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         after_edge();
         waited++;
      end
      idle(2);
      chk("final_drain", longint'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
